// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: legal parameter limits,
// state-width helper and the priority-decoded per-edge command.
package seq_det_pkg;

    localparam int PATTERN_W_MIN = 2;
    localparam int PATTERN_W_MAX = 32;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_BIT   = 2'd1,
        CMD_CLEAR = 2'd2,
        CMD_LOAD  = 2'd3
    } cmd_e;

    // Bits needed to hold a matched-prefix length of 0..pattern_w.
    function automatic int state_w(input int pattern_w);
        return $clog2(pattern_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_match_len.sv
// Combinational next-length search: the longest prefix of the pattern, no longer
// than the cap, that ends with the newest bit and agrees with the bit history.
module seq_det_match_len
    import seq_det_pkg::*;
#(
    parameter int PATTERN_W = 4,
    parameter int STATE_W   = state_w(PATTERN_W)
) (
    input  logic [PATTERN_W-1:0] i_pattern,
    input  logic [PATTERN_W-2:0] i_hist,
    input  logic                 i_bit,
    input  logic [STATE_W-1:0]   i_cap,
    output logic [STATE_W-1:0]   o_len
);

    logic [PATTERN_W-1:0] w_recent;
    logic [PATTERN_W-1:0] w_oldest_first;
    logic                 w_found;

    // w_recent[0] is the newest bit; reversing puts the oldest history bit at index 0,
    // so a right shift lines the last j received bits up against pattern[j-1:0].
    assign w_recent       = {i_hist, i_bit};
    assign w_oldest_first = {<<{w_recent}};

    always_comb begin
        o_len   = '0;
        w_found = 1'b0;
        for (int j = PATTERN_W; j >= 1; j--) begin
            if (!w_found && (j <= int'(i_cap)) &&
                ((((w_oldest_first >> (PATTERN_W - j)) ^ i_pattern) &
                  ({PATTERN_W{1'b1}} >> (PATTERN_W - j))) == '0)) begin
                o_len   = STATE_W'(j);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with a runtime-loadable pattern, overlapping or
// non-overlapping detection, input qualification and a saturating hit counter.
module moore_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W     = 4,
    parameter int                   CNT_W         = 8,
    parameter logic [PATTERN_W-1:0] RESET_PATTERN = PATTERN_W'(4'b1101),
    localparam int                  STATE_W       = state_w(PATTERN_W)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 overlap,
    input  logic                 cfg_load,
    input  logic [PATTERN_W-1:0] cfg_pattern,
    input  logic                 clear,
    output logic                 match,
    output logic [STATE_W-1:0]   state,
    output logic [CNT_W-1:0]     hit_count,
    output logic                 hit_sat
);

    if (PATTERN_W < PATTERN_W_MIN || PATTERN_W > PATTERN_W_MAX) begin : g_bad_pattern_w
        $error("moore_seq_detector: PATTERN_W must be in 2..32");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("moore_seq_detector: CNT_W must be in 1..32");
    end

    logic [PATTERN_W-1:0] r_pattern_q;
    logic [PATTERN_W-2:0] r_hist;
    logic [STATE_W-1:0]   r_state;
    logic [CNT_W-1:0]     r_hit_count;

    logic [PATTERN_W-1:0] w_pattern_nxt;
    logic [PATTERN_W-2:0] w_hist_nxt;
    logic [PATTERN_W-2:0] w_hist_shift;
    logic [STATE_W-1:0]   w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [STATE_W-1:0]   w_cap;
    logic [STATE_W-1:0]   w_len;
    cmd_e                 w_cmd;

    always_comb begin
        if (cfg_load)      w_cmd = CMD_LOAD;
        else if (clear)    w_cmd = CMD_CLEAR;
        else if (in_valid) w_cmd = CMD_BIT;
        else               w_cmd = CMD_IDLE;
    end

    // After a full match, non-overlapping mode only lets the new bit start a fresh prefix.
    always_comb begin
        if (r_state == STATE_W'(PATTERN_W))
            w_cap = overlap ? STATE_W'(PATTERN_W) : STATE_W'(1);
        else
            w_cap = r_state + STATE_W'(1);
    end

    assign w_hist_shift = (PATTERN_W-1)'({r_hist, in_bit});

    seq_det_match_len #(
        .PATTERN_W (PATTERN_W),
        .STATE_W   (STATE_W)
    ) u_match_len (
        .i_pattern (r_pattern_q),
        .i_hist    (r_hist),
        .i_bit     (in_bit),
        .i_cap     (w_cap),
        .o_len     (w_len)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pattern_q <= RESET_PATTERN;
            r_hist      <= '0;
            r_state     <= '0;
            r_hit_count <= '0;
        end else begin
            r_pattern_q <= w_pattern_nxt;
            r_hist      <= w_hist_nxt;
            r_state     <= w_state_nxt;
            r_hit_count <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_pattern_nxt = r_pattern_q;
        w_hist_nxt    = r_hist;
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_hit_count;
        unique case (w_cmd)
            CMD_LOAD: begin
                w_pattern_nxt = cfg_pattern;
                w_hist_nxt    = '0;
                w_state_nxt   = '0;
                w_cnt_nxt     = '0;
            end
            CMD_CLEAR: begin
                w_hist_nxt  = '0;
                w_state_nxt = '0;
                w_cnt_nxt   = '0;
            end
            CMD_BIT: begin
                w_hist_nxt  = w_hist_shift;
                w_state_nxt = w_len;
                if ((w_len == STATE_W'(PATTERN_W)) && !(&r_hit_count))
                    w_cnt_nxt = r_hit_count + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        state     = r_state;
        hit_count = r_hit_count;
        match     = (r_state == STATE_W'(PATTERN_W));
        hit_sat   = &r_hit_count;
    end

endmodule
